// File: rtl/adc_bcd_pkg.sv
// Shared types and constants for the ADC-to-BCD display path.
package adc_bcd_pkg;
  localparam int ADC_W      = 12;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int DD_ITER    = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Double-dabble correction: a nibble of 5..9 gets +3 so the next shift carries into the next decade.
  function automatic bcd_digit_t dabble(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start loads a 12-bit value, 12 SHIFT cycles, then one DONE cycle
// with fresh digits. A start seen while shifting is ignored; the caller decides what that means.
module bin2bcd_seq
  import adc_bcd_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADC_W-1:0]              value,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGITS*BCD_W-1:0]   digits
);
  localparam int BCD_F_W = BCD_DIGITS * BCD_W;
  localparam int SR_W    = BCD_F_W + ADC_W;
  localparam logic [3:0] ITER_LAST = 4'(DD_ITER - 1);

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_adj, sr_shift;
  logic [3:0]         iter_q;
  logic [BCD_F_W-1:0] digits_q;
  logic               last_iter;

  assign last_iter = (iter_q == ITER_LAST);

  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      sr_adj[ADC_W + i*BCD_W +: BCD_W] = dabble(sr_q[ADC_W + i*BCD_W +: BCD_W]);
    end
    sr_shift = {sr_adj[SR_W-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      iter_q   <= '0;
      digits_q <= '0;
    end else begin
      state_q <= state_d;
      if (start && state_q != SHIFT) begin
        sr_q   <= {{BCD_F_W{1'b0}}, value};
        iter_q <= '0;
      end else if (state_q == SHIFT) begin
        sr_q   <= sr_shift;
        iter_q <= iter_q + 4'd1;
        // Capture the final shift directly so the digits are already valid in the DONE cycle.
        if (last_iter) digits_q <= sr_shift[SR_W-1:ADC_W];
      end
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign digits = digits_q;
endmodule

// File: rtl/adc_bcd_converter.sv
// Averages blocks of 2^AVG_LOG2 ADC samples and converts each block average to four BCD digits.
// Latency 13 cycles from the block-completing sample; a block finishing mid-conversion is dropped and sets overrun.
module adc_bcd_converter
  import adc_bcd_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] DATA,
  input  logic             DATA_VALID,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands,
  output logic             bcd_valid,
  output logic             busy,
  output logic             overrun
);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]            acc_q, acc_sum;
  logic [CNT_W-1:0]            cnt_q;
  logic [ADC_W-1:0]            avg;
  logic                        block_done;
  logic                        eng_busy, eng_done;
  logic [BCD_DIGITS*BCD_W-1:0] digits;
  logic                        overrun_q;

  assign acc_sum    = acc_q + ACC_W'(DATA);
  assign avg        = ADC_W'(acc_sum >> AVG_LOG2);
  assign block_done = DATA_VALID && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (DATA_VALID) begin
        acc_q <= block_done ? '0 : acc_sum;
        cnt_q <= block_done ? '0 : cnt_q + 1'b1;
      end
      if (block_done && eng_busy) overrun_q <= 1'b1;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .start  (block_done),
    .value  (avg),
    .busy   (eng_busy),
    .done   (eng_done),
    .digits (digits)
  );

  assign ones      = digits[3:0];
  assign tens      = digits[7:4];
  assign hundreds  = digits[11:8];
  assign thousands = digits[15:12];
  assign bcd_valid = eng_done;
  assign busy      = eng_busy;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_adc_bcd_converter.sv
// Directed bench for adc_bcd_converter: one instance without averaging, one averaging blocks of 4.
module tb_adc_bcd_converter;
  logic        clk;
  logic        rst_n;
  logic [11:0] d0, d2;
  logic        v0, v2;
  logic [3:0]  o0, t0, h0, th0, o2, t2, h2, th2;
  logic        bv0, bz0, ov0, bv2, bz2, ov2;

  int errors = 0;
  int checks = 0;
  logic [15:0] q0[$];
  logic [15:0] q2[$];
  logic [15:0] last0 = '0;
  logic [15:0] last2 = '0;

  adc_bcd_converter #(.AVG_LOG2(0)) u0 (
    .clk(clk), .reset(rst_n), .DATA(d0), .DATA_VALID(v0),
    .ones(o0), .tens(t0), .hundreds(h0), .thousands(th0),
    .bcd_valid(bv0), .busy(bz0), .overrun(ov0)
  );

  adc_bcd_converter #(.AVG_LOG2(2)) u2 (
    .clk(clk), .reset(rst_n), .DATA(d2), .DATA_VALID(v2),
    .ones(o2), .tens(t2), .hundreds(h2), .thousands(th2),
    .bcd_valid(bv2), .busy(bz2), .overrun(ov2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic digits_legal(input logic [15:0] d);
    return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9) && (d[11:8] <= 4'd9) && (d[15:12] <= 4'd9);
  endfunction

  // Scoreboard: every bcd_valid pulse must match the oldest expected value; digits hold otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bv0) begin
        if (q0.size() == 0) chk("u0_unexpected_pulse", {th0, h0, t0, o0}, 32'hFFFF_FFFF);
        else chk("u0_digits", {th0, h0, t0, o0}, q0.pop_front());
        chk("u0_nibbles_legal", digits_legal({th0, h0, t0, o0}), 1);
      end else if ({th0, h0, t0, o0} !== last0) begin
        chk("u0_digits_stable", {th0, h0, t0, o0}, last0);
      end
      if (bv2) begin
        if (q2.size() == 0) chk("u2_unexpected_pulse", {th2, h2, t2, o2}, 32'hFFFF_FFFF);
        else chk("u2_digits", {th2, h2, t2, o2}, q2.pop_front());
      end else if ({th2, h2, t2, o2} !== last2) begin
        chk("u2_digits_stable", {th2, h2, t2, o2}, last2);
      end
    end
    last0 = {th0, h0, t0, o0};
    last2 = {th2, h2, t2, o2};
  end

  task automatic strobe0(input logic [11:0] v);
    d0 = v; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
  endtask

  task automatic strobe2(input logic [11:0] v);
    d2 = v; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
  endtask

  // Counts negedges (first one = current) until bcd_valid, and busy cycles along the way.
  task automatic wait_pulse(input bit sel, output int n, output int bn);
    bit seen;
    n = 1; bn = 0; seen = 1'b0;
    while (n < 60) begin
      if (sel ? bz2 : bz0) bn++;
      if (sel ? bv2 : bv0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    chk(sel ? "u2_pulse_seen" : "u0_pulse_seen", seen, 1);
  endtask

  int n, bn;
  int sweep[7] = '{9, 10, 99, 100, 999, 1000, 4094};

  initial begin
    rst_n = 1'b1; d0 = '0; v0 = 1'b0; d2 = '0; v2 = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_digits0", {th0, h0, t0, o0}, 0);
    chk("rst_bcd_valid0", bv0, 0);
    chk("rst_busy0", bz0, 0);
    chk("rst_overrun0", ov0, 0);
    chk("rst_digits2", {th2, h2, t2, o2}, 0);
    chk("rst_busy2", bz2, 0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-scale sample: 13-cycle latency, busy for exactly 12 cycles.
    q0.push_back(16'h4095);
    strobe0(12'd4095);
    wait_pulse(0, n, bn);
    chk("fullscale_latency", n, 13);
    chk("fullscale_busy_cycles", bn, 12);
    @(negedge clk);
    chk("fullscale_busy_after", bz0, 0);
    chk("fullscale_valid_one_cycle", bv0, 0);

    // Zero then 1234, 20 cycles apart.
    q0.push_back(16'h0000);
    strobe0(12'd0);
    wait_pulse(0, n, bn);
    repeat (7) @(negedge clk);
    q0.push_back(16'h1234);
    strobe0(12'd1234);
    wait_pulse(0, n, bn);
    chk("val1234_latency", n, 13);
    repeat (3) @(negedge clk);

    // Averaging block of four: nothing until the fourth sample.
    strobe2(12'd1000); @(negedge clk);
    strobe2(12'd1001); @(negedge clk);
    strobe2(12'd1002); repeat (3) @(negedge clk);
    chk("avg_no_busy_after_3", bz2, 0);
    q2.push_back(16'h1001);
    strobe2(12'd1003);
    wait_pulse(1, n, bn);
    chk("avg_latency", n, 13);
    chk("avg_busy_cycles", bn, 12);
    repeat (3) @(negedge clk);

    // Overrun: block at t+5 dropped, block in the DONE cycle accepted.
    q0.push_back(16'h0999);
    strobe0(12'd999);
    repeat (4) @(negedge clk);
    chk("overrun_clear_before", ov0, 0);
    strobe0(12'd500);
    chk("overrun_set", ov0, 1);
    wait_pulse(0, n, bn);
    chk("overrun_first_latency", n, 8);
    q0.push_back(16'h0500);
    strobe0(12'd500);
    wait_pulse(0, n, bn);
    chk("done_cycle_accept_latency", n, 13);
    chk("overrun_sticky", ov0, 1);
    repeat (3) @(negedge clk);

    // Reset mid-conversion, with a partial block pending in the averaging instance.
    strobe2(12'd3000);
    strobe2(12'd3000);
    strobe0(12'd1234);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_digits0", {th0, h0, t0, o0}, 0);
    chk("midrst_busy0", bz0, 0);
    chk("midrst_valid0", bv0, 0);
    chk("midrst_overrun0", ov0, 0);
    chk("midrst_digits2", {th2, h2, t2, o2}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    strobe2(12'd2000);
    strobe2(12'd2004);
    strobe2(12'd2008);
    repeat (2) @(negedge clk);
    chk("postrst_no_busy2", bz2, 0);
    chk("postrst_no_busy0", bz0, 0);
    q2.push_back(16'h2005);
    strobe2(12'd2011);
    wait_pulse(1, n, bn);
    chk("postrst_avg_latency", n, 13);
    repeat (3) @(negedge clk);

    // Decade boundary sweep.
    foreach (sweep[i]) begin
      q0.push_back(to_bcd(sweep[i]));
      strobe0(12'(sweep[i]));
      wait_pulse(0, n, bn);
      chk("sweep_latency", n, 13);
      repeat (2) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("u0_queue_drained", q0.size(), 0);
    chk("u2_queue_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adc_bcd_converter.md
# adc_bcd_converter

Consumes 12-bit samples from the SPI ADC reader (`DATA`/`DATA_VALID`), optionally averages a block of 2^AVG_LOG2 samples, and converts the result to four BCD digits with a sequential double-dabble engine. It sits between the SPI state machine and the 7-segment controller. Its `ones`/`tens`/`hundreds`/`thousands` outputs drive the display directly, so the display shows the live ADC reading instead of the free-running counter.

## Interface

Parameters:
- `AVG_LOG2`, default 2: log2 of the averaging block length. Legal range 0..4; 0 means no averaging.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `DATA` input 12: ADC sample. Valid only while `DATA_VALID`=1.
- `DATA_VALID` input 1: single-cycle sample strobe.
- `ones` output 4: BCD digit, 10^0.
- `tens` output 4: BCD digit, 10^1.
- `hundreds` output 4: BCD digit, 10^2.
- `thousands` output 4: BCD digit, 10^3.
- `bcd_valid` output 1: one-cycle pulse in the cycle the digits update.
- `busy` output 1: high while a conversion is in progress.
- `overrun` output 1: sticky flag, set when a completed block average is dropped.

## Operation

- **Reset values.** Reset low forces all digits to 0, `bcd_valid`=0, `busy`=0, `overrun`=0, accumulator=0, sample count=0, FSM=IDLE. This applies immediately and asynchronously, including mid-conversion.
- **Accumulator.**
  - Width is 12+AVG_LOG2 bits; it never overflows (max 4095·16).
  - Each `DATA_VALID` adds `DATA` and increments the sample count. This happens in every FSM state.
  - When the count reaches 2^AVG_LOG2, a block completes:
    - average = accumulator >> AVG_LOG2 (truncation, no rounding; 12-bit result);
    - the accumulator and count clear in the same edge. The completing sample is included in the block; the next sample starts a new block.
- **Start of conversion.**
  - If the FSM is IDLE or DONE when a block completes, the average is loaded into the shift register and the FSM enters SHIFT.
  - If the FSM is SHIFT, the average is discarded, `overrun` is set, and the current conversion continues unaffected.
- **FSM states:**
  - IDLE: waits for a block to complete.
  - SHIFT: 12 cycles of double-dabble. Each cycle, any BCD nibble ≥5 gets +3, then the {bcd, bin} register shifts left by 1.
  - DONE: lasts one cycle. Digits are registered from the BCD field and `bcd_valid`=1. Next state is SHIFT if a block completes in this cycle, otherwise IDLE.
- **Outputs.**
  - `busy`=1 exactly while the FSM is in SHIFT.
  - Digits hold their value between DONE cycles.
  - The 16-bit BCD field covers 0..4095, so `thousands` is ≤4.
- **Overrun** is cleared only by reset.

## Timing

- Let t be the cycle where `DATA_VALID`=1 completes a block and the FSM is IDLE.
  - Cycles t+1..t+12 are SHIFT, with `busy`=1.
  - Cycle t+13 is DONE: the new digits are visible on the outputs and `bcd_valid`=1 for that single cycle.
- Latency from block-completing sample to `bcd_valid` is 13 cycles.
- Throughput is one conversion per 13 cycles. A block completing in the DONE cycle is accepted without overrun.
- A block completing in any SHIFT cycle, including t+12, causes an overrun.
- Reset deasserting mid-conversion leaves the FSM in IDLE. The partial accumulator is discarded; no `bcd_valid` occurs until a fresh full block completes.
- `DATA` is sampled only in cycles where `DATA_VALID`=1. `DATA_VALID` held high for k cycles counts as k samples.

## Structure

- **Shared package `adc_bcd_pkg`:**
  - `ADC_W`=12;
  - `BCD_DIGITS`=4;
  - `BCD_W`=4;
  - `DD_ITER`=12;
  - FSM state typedef {IDLE, SHIFT, DONE};
  - BCD digit typedef.
- **Sub-module `bin2bcd_seq`:** the double-dabble engine. It holds the FSM, the shift register, the iteration counter and the output digit registers, with a start/value input and a done/digits output.
- **Top `adc_bcd_converter`:** holds the accumulator, the sample counter, the overrun logic and the `bin2bcd_seq` instance.

## Test plan

- AVG_LOG2=0, `DATA`=4095 with one strobe → 13 cycles later `bcd_valid` pulses once; `thousands,hundreds,tens,ones` = 4,0,9,5; `busy` is high for exactly 12 cycles.
- AVG_LOG2=0, `DATA`=0, then 1234, spaced 20 cycles apart → digits 0,0,0,0, then 1,2,3,4; digits are stable between pulses.
- AVG_LOG2=2, samples 1000, 1001, 1002, 1003 → sum 4006 >> 2 = 1001; digits 1,0,0,1; no `bcd_valid` after the first 3 samples.
- AVG_LOG2=0, strobes 999 at t and 500 at t+5 → digits 0,9,9,9; `overrun`=1 and stays 1; no second pulse. A third strobe 500 at t+13 is accepted, giving digits 0,5,0,0 with `overrun` still 1.
- Assert reset at t+6 of a conversion → all digits 0 and `busy`/`bcd_valid`/`overrun`=0 immediately. After release, with AVG_LOG2=2, three samples produce nothing and the fourth yields the correct average.
- Boundary sweep AVG_LOG2=0 over the values 9, 10, 99, 100, 999, 1000, 4094 → every value produces exact BCD digits, and no nibble ever shows 10..15.
